// File: rtl/max_pool_2x2.sv
// -----------------------------------------------------------------------------
// max_pool_2x2
//   2x2, stride-2 signed max pooling over a row-major raster stream of conv
//   results. Horizontal pair maxima from even rows are parked in a half-width
//   line buffer. On odd rows they are combined with the current pair maximum to
//   form one pooled value per 2x2 window.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : input sample strobe (bubbles hold all state)
//   data_in    : signed conv result, DATA_BITS wide
//   clear      : synchronous frame restart, has priority over in_valid
//   out_valid  : one-cycle pulse, pooled sample valid
//   data_out   : signed pooled maximum, holds between pulses
//   frame_done : one-cycle pulse with the last out_valid of a frame
// -----------------------------------------------------------------------------
module max_pool_2x2 #(
  parameter int IN_WIDTH  = 14,
  parameter int IN_HEIGHT = 14,
  parameter int DATA_BITS = 6,
  parameter int COL_BITS  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic signed [DATA_BITS-1:0] data_in,
  input  logic                        clear,
  output logic                        out_valid,
  output logic signed [DATA_BITS-1:0] data_out,
  output logic                        frame_done
);

  localparam int HALF_W = (IN_WIDTH / 2 > 0) ? IN_WIDTH / 2 : 1;
  localparam int LB_AW  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(IN_WIDTH - 1);
  localparam logic [COL_BITS-1:0] ROW_LAST = COL_BITS'(IN_HEIGHT - 1);
  // Position of the last complete window; odd trailing column/row are dropped.
  localparam logic [COL_BITS-1:0] COL_FD   = COL_BITS'(2 * (IN_WIDTH / 2) - 1);
  localparam logic [COL_BITS-1:0] ROW_FD   = COL_BITS'(2 * (IN_HEIGHT / 2) - 1);

  function automatic logic signed [DATA_BITS-1:0] smax(
    input logic signed [DATA_BITS-1:0] a,
    input logic signed [DATA_BITS-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  logic [COL_BITS-1:0]         col_q, col_d;
  logic [COL_BITS-1:0]         row_q, row_d;
  logic signed [DATA_BITS-1:0] h_q, h_d;
  logic signed [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                        out_valid_q, out_valid_d;
  logic                        frame_done_q, frame_done_d;

  logic signed [DATA_BITS-1:0] line_buf [HALF_W];
  logic signed [DATA_BITS-1:0] lb_rd_q;
  logic                        lb_we;
  logic                        lb_re;
  logic [LB_AW-1:0]            lb_addr;
  logic signed [DATA_BITS-1:0] h_pair;

  assign lb_addr = col_q[LB_AW:1];
  assign h_pair  = smax(h_q, data_in);

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    h_d          = h_q;
    data_out_d   = data_out_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    lb_we        = 1'b0;
    lb_re        = 1'b0;

    if (clear) begin
      col_d = '0;
      row_d = '0;
      h_d   = '0;
    end else if (in_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      if (!col_q[0]) begin
        h_d = data_in;
        // Fetch the stored upper-row pair one sample early so the buffer read
        // is registered and ready when the odd column arrives.
        lb_re = row_q[0];
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        data_out_d   = smax(lb_rd_q, h_pair);
        out_valid_d  = 1'b1;
        frame_done_d = (row_q == ROW_FD) && (col_q == COL_FD);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      h_q          <= '0;
      data_out_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      h_q          <= h_d;
      data_out_q   <= data_out_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer is not reset: row 0 of every frame rewrites each entry before
  // an odd row can read it.
  always_ff @(posedge clk) begin
    if (lb_we) line_buf[lb_addr] <= h_pair;
    if (lb_re) lb_rd_q <= line_buf[lb_addr];
  end

  assign out_valid  = out_valid_q;
  assign data_out   = data_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
module tb_max_pool_2x2;

  typedef struct {
    logic              vld;
    logic              clr;
    logic signed [5:0] din;
    logic              ov;
    logic signed [5:0] dout;
    logic              fd;
  } vec_t;

  typedef struct {
    logic signed [5:0] d;
    logic              fd;
    int                cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: 4x2 frame, DUT B: 5x3 frame (odd dimensions)
  logic              rst_n_a, vld_a, clr_a, ov_a, fd_a;
  logic signed [5:0] din_a, dout_a;
  logic              rst_n_b, vld_b, clr_b, ov_b, fd_b;
  logic signed [5:0] din_b, dout_b;

  max_pool_2x2 #(.IN_WIDTH(4), .IN_HEIGHT(2), .DATA_BITS(6), .COL_BITS(4)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .in_valid(vld_a), .data_in(din_a), .clear(clr_a),
    .out_valid(ov_a), .data_out(dout_a), .frame_done(fd_a)
  );

  max_pool_2x2 #(.IN_WIDTH(5), .IN_HEIGHT(3), .DATA_BITS(6), .COL_BITS(4)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .in_valid(vld_b), .data_in(din_b), .clear(clr_b),
    .out_valid(ov_b), .data_out(dout_b), .frame_done(fd_b)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_a[$];
  exp_t exp_b[$];
  vec_t vq_a[$];
  vec_t vq_b[$];
  exp_t ea, eb;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic vec_t mk(input logic vld, input logic clr, input int d,
                              input logic ov, input int dout, input logic fd);
    vec_t r;
    r.vld  = vld;
    r.clr  = clr;
    r.din  = 6'(d);
    r.ov   = ov;
    r.dout = 6'(dout);
    r.fd   = fd;
    return r;
  endfunction

  // Drive one vector at the falling edge; the next rising edge accepts it.
  task automatic drive(input int sel, input vec_t v);
    exp_t e;
    @(negedge clk);
    if (sel == 0) begin
      vld_a = v.vld; clr_a = v.clr; din_a = v.din;
    end else begin
      vld_b = v.vld; clr_b = v.clr; din_b = v.din;
    end
    if (v.ov) begin
      e.d   = v.dout;
      e.fd  = v.fd;
      e.cyc = cyc + 1;
      if (sel == 0) exp_a.push_back(e);
      else          exp_b.push_back(e);
    end
  endtask

  // A 4x2 frame given as 8 samples; windows close at sample 5 and sample 7.
  task automatic add_4x2(input int d[8], input int gap, input int o0, input int o1);
    for (int i = 0; i < 8; i++) begin
      vq_a.push_back(mk(1'b1, 1'b0, d[i], (i == 5) || (i == 7),
                        (i == 7) ? o1 : o0, i == 7));
      for (int g = 0; g < gap; g++) vq_a.push_back(mk(1'b0, 1'b0, 0, 1'b0, 0, 1'b0));
    end
  endtask

  // A 5x3 frame given as 15 samples; windows close at samples 6 and 8.
  task automatic add_5x3(input int d[15], input int o0, input int o1);
    for (int i = 0; i < 15; i++)
      vq_b.push_back(mk(1'b1, 1'b0, d[i], (i == 6) || (i == 8),
                        (i == 8) ? o1 : o0, i == 8));
  endtask

  task automatic run_queues();
    for (int i = 0; i < vq_a.size(); i++) drive(0, vq_a[i]);
    for (int i = 0; i < vq_b.size(); i++) drive(1, vq_b[i]);
    vq_a.delete();
    vq_b.delete();
    drive(0, mk(1'b0, 1'b0, 0, 1'b0, 0, 1'b0));
    drive(1, mk(1'b0, 1'b0, 0, 1'b0, 0, 1'b0));
  endtask

  // Scoreboard monitors: pop one expectation per out_valid pulse.
  always @(negedge clk) begin
    if (ov_a) begin
      if (exp_a.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL a_unexpected_pulse: got out_valid=1 data_out=%0d, required no pulse (cycle %0d)", dout_a, cyc);
      end else begin
        ea = exp_a.pop_front();
        chk("a_data_out", int'(dout_a), int'(ea.d));
        chk("a_frame_done", int'(fd_a), int'(ea.fd));
        chk("a_out_cycle", cyc, ea.cyc);
      end
    end else if (fd_a) begin
      n_cmp++; n_bad++;
      $display("FAIL a_stray_frame_done: got frame_done=1 without out_valid, required 0 (cycle %0d)", cyc);
    end
  end

  always @(negedge clk) begin
    if (ov_b) begin
      if (exp_b.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_unexpected_pulse: got out_valid=1 data_out=%0d, required no pulse (cycle %0d)", dout_b, cyc);
      end else begin
        eb = exp_b.pop_front();
        chk("b_data_out", int'(dout_b), int'(eb.d));
        chk("b_frame_done", int'(fd_b), int'(eb.fd));
        chk("b_out_cycle", cyc, eb.cyc);
      end
    end else if (fd_b) begin
      n_cmp++; n_bad++;
      $display("FAIL b_stray_frame_done: got frame_done=1 without out_valid, required 0 (cycle %0d)", cyc);
    end
  end

  initial begin
    int s1[8]    = '{1, 5, -3, 2, 4, -8, 7, 0};
    int sat[8]   = '{-32, -32, -32, 31, -32, -32, -32, -32};
    int ramp[15] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
    int fr2[15]  = '{-1, -2, -3, -4, 25, -5, -6, -7, -8, 25, 20, 20, 20, 20, 20};
    int fr3[15]  = '{1, 5, -3, 2, 30, 4, -8, 7, 0, 30, 31, 31, 31, 31, 31};

    rst_n_a = 1'b0; vld_a = 1'b0; clr_a = 1'b0; din_a = '0;
    rst_n_b = 1'b0; vld_b = 1'b0; clr_b = 1'b0; din_b = '0;
    repeat (3) @(negedge clk);
    chk("a_reset_out_valid", int'(ov_a), 0);
    chk("a_reset_frame_done", int'(fd_a), 0);
    chk("a_reset_data_out", int'(dout_a), 0);
    chk("b_reset_out_valid", int'(ov_b), 0);
    chk("b_reset_frame_done", int'(fd_b), 0);
    chk("b_reset_data_out", int'(dout_b), 0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    // DUT A table: basic frame, saturation extremes, then the basic frame
    // with three idle cycles between samples.
    add_4x2(s1, 0, 5, 7);
    add_4x2(sat, 0, -32, 31);
    add_4x2(s1, 3, 5, 7);

    // DUT B table: ramp with dropped column/row, back-to-back second frame,
    // six-sample partial frame, clear (with a sample), then a fresh frame.
    add_5x3(ramp, 6, 8);
    add_5x3(fr2, -1, -3);
    for (int i = 0; i < 6; i++) vq_b.push_back(mk(1'b1, 1'b0, 31, 1'b0, 0, 1'b0));
    vq_b.push_back(mk(1'b1, 1'b1, 31, 1'b0, 0, 1'b0));
    add_5x3(fr3, 5, 7);

    run_queues();

    // Async reset during row 1 of DUT A, just as a pooled pulse is showing.
    for (int i = 0; i < 6; i++)
      drive(0, mk(1'b1, 1'b0, 10, i == 5, 10, 1'b0));
    drive(0, mk(1'b0, 1'b0, 0, 1'b0, 0, 1'b0));
    #1;
    rst_n_a = 1'b0;
    #1;
    chk("a_async_out_valid", int'(ov_a), 0);
    chk("a_async_frame_done", int'(fd_a), 0);
    chk("a_async_data_out", int'(dout_a), 0);
    #1;
    rst_n_a = 1'b1;

    add_4x2(s1, 0, 5, 7);
    run_queues();

    repeat (4) @(negedge clk);
    chk("a_pending_outputs", exp_a.size(), 0);
    chk("b_pending_outputs", exp_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
